dunc16_control_unit: RTL and testbench
======================================

Name: dunc16_control_unit

Overview:
- Instruction sequencer for the DUNC16 accumulator datapath (PC, MA, MD, AC, IR).
- Runs a four-phase T0–T3 timing ring inside alternating FETCH and EXECUTE cycles, and owns the 4-bit IR.
- Decodes the opcode into register enables, mux selects and memory strobes, and stalls on a memory-ready handshake.
- Sits between the datapath registers and the memory port. It replaces hand-wired schematic decode.

Parameters:
HALT_OP, 4'hF, opcode that enters HALT.
WAIT_EN, 1, 1 = stall phases that carry MEM_RD/MEM_WR until MEM_READY; 0 = ignore MEM_READY (single-cycle memory).

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RESET  in  1  asynchronous, active-low reset.
MD_OP  in  4  MD[15:12], opcode field of the fetched word.
AN  in  1  AC negative flag (AC[15]).
AZ  in  1  AC zero flag.
MEM_READY  in  1  memory completes the current read or write this cycle.
T0, T1, T2, T3  out  1 each  one-hot phase.
FETCH  out  1  fetch cycle active.
EXECUTE  out  1  execute cycle active (equals ~FETCH unless halted).
FETCH_T1  out  1  FETCH & T1.
IR_OUT  out  4  instruction register.
I_LDA, I_STA, I_ADD, I_SUB, I_JMP, I_BAN, I_BAZ  out  1 each  decoded IR.
EN_PC, EN_MA, EN_MD, EN_AC  out  1 each  datapath register load enables.
PC_SEL  out  1  0 = PC+1, 1 = MD[11:0].
MA_SEL  out  1  0 = PC, 1 = MD[11:0].
MD_SEL  out  1  0 = memory read data, 1 = AC.
AC_SEL  out  1  0 = MD, 1 = ALU result.
ALU_SUB  out  1  ALU subtracts (AC-MD) when 1, adds when 0.
MEM_RD  out  1  memory read strobe.
MEM_WR  out  1  memory write strobe.
HALTED  out  1  controller is in HALT.

Behaviour:
- State: phase ring (T0..T3), cycle flag (FETCH/EXECUTE), HALT flag, IR[3:0].
- Reset (RESET=0, asynchronous): FETCH, T0, IR=0, HALTED=0. All enables, strobes and selects are forced 0 while RESET=0. After release, the first edge executes FETCH T0.
- Outputs are combinational from registered state, IR, AN and AZ. The datapath consumes them at the next rising edge.
- Phase advance: T0→T1→T2→T3→T0 each edge. At the T3→T0 transition, FETCH and EXECUTE toggle.
- Stall: when WAIT_EN=1 and the current phase asserts MEM_RD or MEM_WR with MEM_READY=0:
  - phase, cycle and IR hold;
  - all EN_* are forced 0 except the strobe itself;
  - the strobe stays high until a cycle with MEM_READY=1.
- FETCH cycle:
  - T0: EN_MA, MA_SEL=0.
  - T1: MEM_RD, EN_MD, MD_SEL=0, EN_PC, PC_SEL=0.
  - T2: IR<=MD_OP, EN_MA, MA_SEL=1.
  - T3: no enables.
- EXECUTE cycle, by IR:
  - LDA (0): T1 MEM_RD+EN_MD; T2 EN_AC, AC_SEL=0.
  - STA (1): T0 EN_MD, MD_SEL=1; T1 MEM_WR.
  - ADD (2) / SUB (3): T1 MEM_RD+EN_MD; T2 EN_AC, AC_SEL=1, ALU_SUB=(IR==3).
  - JMP (4): T0 EN_PC, PC_SEL=1.
  - BAN (5): as JMP when AN=1 at T0, else no enables.
  - BAZ (6): as JMP when AZ=1 at T0, else no enables.
  - HALT_OP: at T3, enter HALT instead of FETCH T0.
  - All other opcodes: NOP (full 4-phase execute, no enables).
- HALT: T0..T3 all 0, FETCH=EXECUTE=0, HALTED=1, all enables 0. Exit only via reset.
- I_* decodes follow IR_OUT in both cycles. Phase outputs are always one-hot outside HALT.
- Reset asserted mid-stall or mid-execute aborts immediately. No strobe survives into the reset-released state.
- Instruction latency with zero wait: 8 cycles (4 fetch + 4 execute).

Test Plan:
- Reset held 2 cycles, then released → T0=1, FETCH=1, all EN_*/MEM_* = 0 during reset; first edge gives EN_MA=1, MA_SEL=0.
- Program LDA 0x00A, ADD 0x00B, STA 0x00C, HALT with mem[A]=0x0005, mem[B]=0x0003, MEM_READY tied 1 → mem[C]=0x0008, HALTED=1 after 32 cycles, PC=4.
- SUB giving AC=0xFFFE, then BAN 0x020 → PC_SEL=1 and EN_PC=1 at EXECUTE T0, next fetch from 0x020. Repeat with AC=0x0001 → no branch, PC continues at 0x002+.
- MEM_READY=0 for 3 cycles during FETCH T1 → MEM_RD held 4 cycles, T1 held, EN_PC pulses once (the ready cycle); total instruction 11 cycles.
- RESET pulsed low during EXECUTE T1 of STA (MEM_WR=1) → MEM_WR drops asynchronously; after release FETCH T0, IR=0.
- Undefined opcode 0x9 → 4 execute phases with no EN_*/MEM_* asserted; next fetch proceeds normally.

Source files
------------

// File: rtl/dunc16_control_unit.sv
// dunc16_control_unit
//   Instruction sequencer for the DUNC16 accumulator datapath. A four-phase
//   T0..T3 ring runs inside alternating FETCH and EXECUTE cycles, and the
//   4-bit IR is owned here. The opcode decode drives the datapath register
//   enables, the mux selects and the memory strobes. Phases that carry a
//   memory strobe stall until MEM_READY.
//
// Ports
//   CLK, RESET            clock (rising edge), asynchronous active-low reset
//   MD_OP[3:0]            MD[15:12], opcode field of the fetched word
//   AN, AZ                accumulator negative / zero flags
//   MEM_READY             memory completes the current read/write this cycle
//   T0..T3                one-hot phase (all 0 in HALT)
//   FETCH, EXECUTE        cycle flags; FETCH_T1 = FETCH & T1
//   IR_OUT[3:0]           instruction register
//   I_LDA..I_BAZ          decoded IR
//   EN_PC/MA/MD/AC        datapath load enables
//   PC_SEL, MA_SEL,
//   MD_SEL, AC_SEL        datapath mux selects
//   ALU_SUB               ALU subtracts when 1
//   MEM_RD, MEM_WR        memory strobes
//   HALTED                controller is halted (exit only via reset)
`timescale 1ns/1ps
module dunc16_control_unit #(
  parameter logic [3:0] HALT_OP = 4'hF,
  parameter logic       WAIT_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MD_OP,
  input  logic       AN,
  input  logic       AZ,
  input  logic       MEM_READY,
  output logic       T0,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic       FETCH,
  output logic       EXECUTE,
  output logic       FETCH_T1,
  output logic [3:0] IR_OUT,
  output logic       I_LDA,
  output logic       I_STA,
  output logic       I_ADD,
  output logic       I_SUB,
  output logic       I_JMP,
  output logic       I_BAN,
  output logic       I_BAZ,
  output logic       EN_PC,
  output logic       EN_MA,
  output logic       EN_MD,
  output logic       EN_AC,
  output logic       PC_SEL,
  output logic       MA_SEL,
  output logic       MD_SEL,
  output logic       AC_SEL,
  output logic       ALU_SUB,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       HALTED
);

  typedef enum logic [1:0] {PH_T0, PH_T1, PH_T2, PH_T3} phase_t;
  typedef enum logic [1:0] {CYC_FETCH, CYC_EXEC, CYC_HALT} cycle_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_BAN = 4'h5;
  localparam logic [3:0] OP_BAZ = 4'h6;

  phase_t     phase_q, phase_d;
  cycle_t     cycle_q, cycle_d;
  logic [3:0] ir_q, ir_d;

  // Raw decode before stall/reset gating
  logic pc_en, ma_en, md_en, ac_en;
  logic pc_sel, ma_sel, md_sel, ac_sel, alu_sub, rd, wr;
  logic stall, take;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      phase_q <= PH_T0;
      cycle_q <= CYC_FETCH;
      ir_q    <= '0;
    end else begin
      phase_q <= phase_d;
      cycle_q <= cycle_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    pc_en = 1'b0; ma_en = 1'b0; md_en = 1'b0; ac_en = 1'b0;
    pc_sel = 1'b0; ma_sel = 1'b0; md_sel = 1'b0; ac_sel = 1'b0;
    alu_sub = 1'b0; rd = 1'b0; wr = 1'b0;
    take = (ir_q == OP_JMP) || (ir_q == OP_BAN && AN) || (ir_q == OP_BAZ && AZ);

    case (cycle_q)
      CYC_FETCH: begin
        case (phase_q)
          PH_T0: ma_en = 1'b1;
          PH_T1: begin rd = 1'b1; md_en = 1'b1; pc_en = 1'b1; end
          PH_T2: begin ma_en = 1'b1; ma_sel = 1'b1; end
          default: ;
        endcase
      end
      CYC_EXEC: begin
        case (ir_q)
          OP_LDA, OP_ADD, OP_SUB: begin
            if (phase_q == PH_T1) begin rd = 1'b1; md_en = 1'b1; end
            if (phase_q == PH_T2) begin
              ac_en   = 1'b1;
              ac_sel  = (ir_q != OP_LDA);
              alu_sub = (ir_q == OP_SUB);
            end
          end
          OP_STA: begin
            if (phase_q == PH_T0) begin md_en = 1'b1; md_sel = 1'b1; end
            if (phase_q == PH_T1) wr = 1'b1;
          end
          OP_JMP, OP_BAN, OP_BAZ: begin
            if (phase_q == PH_T0 && take) begin pc_en = 1'b1; pc_sel = 1'b1; end
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    stall = WAIT_EN && (rd || wr) && !MEM_READY;

    phase_d = phase_q;
    cycle_d = cycle_q;
    ir_d    = ir_q;
    if (cycle_q != CYC_HALT && !stall) begin
      unique case (phase_q)
        PH_T0: phase_d = PH_T1;
        PH_T1: phase_d = PH_T2;
        PH_T2: phase_d = PH_T3;
        PH_T3: begin
          phase_d = PH_T0;
          if (cycle_q == CYC_FETCH)
            cycle_d = CYC_EXEC;
          else
            cycle_d = (ir_q == HALT_OP) ? CYC_HALT : CYC_FETCH;
        end
      endcase
      if (cycle_q == CYC_FETCH && phase_q == PH_T2) ir_d = MD_OP;
    end
  end

  // Phase/cycle outputs straight from state; controls gated by reset,
  // enables additionally gated while a strobe waits on memory.
  always_comb begin
    HALTED   = (cycle_q == CYC_HALT);
    T0       = !HALTED && phase_q == PH_T0;
    T1       = !HALTED && phase_q == PH_T1;
    T2       = !HALTED && phase_q == PH_T2;
    T3       = !HALTED && phase_q == PH_T3;
    FETCH    = (cycle_q == CYC_FETCH);
    EXECUTE  = (cycle_q == CYC_EXEC);
    FETCH_T1 = FETCH && T1;
    IR_OUT   = ir_q;
    I_LDA    = (ir_q == OP_LDA);
    I_STA    = (ir_q == OP_STA);
    I_ADD    = (ir_q == OP_ADD);
    I_SUB    = (ir_q == OP_SUB);
    I_JMP    = (ir_q == OP_JMP);
    I_BAN    = (ir_q == OP_BAN);
    I_BAZ    = (ir_q == OP_BAZ);
    EN_PC    = RESET && !stall && pc_en;
    EN_MA    = RESET && !stall && ma_en;
    EN_MD    = RESET && !stall && md_en;
    EN_AC    = RESET && !stall && ac_en;
    PC_SEL   = RESET && pc_sel;
    MA_SEL   = RESET && ma_sel;
    MD_SEL   = RESET && md_sel;
    AC_SEL   = RESET && ac_sel;
    ALU_SUB  = RESET && alu_sub;
    MEM_RD   = RESET && rd;
    MEM_WR   = RESET && wr;
  end

endmodule

// File: tb/tb_dunc16_control_unit.sv
`timescale 1ns/1ps
module tb_dunc16_control_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ready = 1'b1;
  logic [3:0] md_op;
  logic       an, az;
  logic       T0, T1, T2, T3, FETCH, EXECUTE, FETCH_T1;
  logic [3:0] IR_OUT;
  logic       I_LDA, I_STA, I_ADD, I_SUB, I_JMP, I_BAN, I_BAZ;
  logic       EN_PC, EN_MA, EN_MD, EN_AC, PC_SEL, MA_SEL, MD_SEL, AC_SEL, ALU_SUB;
  logic       MEM_RD, MEM_WR, HALTED;

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  dunc16_control_unit #(.HALT_OP(4'hF), .WAIT_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .MD_OP(md_op), .AN(an), .AZ(az), .MEM_READY(ready),
    .T0(T0), .T1(T1), .T2(T2), .T3(T3), .FETCH(FETCH), .EXECUTE(EXECUTE),
    .FETCH_T1(FETCH_T1), .IR_OUT(IR_OUT),
    .I_LDA(I_LDA), .I_STA(I_STA), .I_ADD(I_ADD), .I_SUB(I_SUB),
    .I_JMP(I_JMP), .I_BAN(I_BAN), .I_BAZ(I_BAZ),
    .EN_PC(EN_PC), .EN_MA(EN_MA), .EN_MD(EN_MD), .EN_AC(EN_AC),
    .PC_SEL(PC_SEL), .MA_SEL(MA_SEL), .MD_SEL(MD_SEL), .AC_SEL(AC_SEL),
    .ALU_SUB(ALU_SUB), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .HALTED(HALTED)
  );

  // Datapath and 64-word memory driven by the controller's outputs
  logic [11:0] pc, ma;
  logic [15:0] md, ac;
  logic [15:0] mem [64];
  logic [15:0] init_mem [64];

  assign md_op = md[15:12];
  assign an    = ac[15];
  assign az    = (ac == 16'd0);

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc <= '0; ma <= '0; md <= '0; ac <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else begin
      if (EN_MA) ma <= MA_SEL ? md[11:0] : pc;
      if (EN_PC) pc <= PC_SEL ? md[11:0] : pc + 12'd1;
      if (EN_MD) md <= MD_SEL ? ac : mem[ma[5:0]];
      if (EN_AC) ac <= AC_SEL ? (ALU_SUB ? ac - md : ac + md) : md;
      if (MEM_WR && ready) mem[ma[5:0]] <= md;
    end
  end

  // Behavioural model: an instruction is 8 steps (0-3 fetch, 4-7 execute)
  typedef struct packed {
    logic en_pc, en_ma, en_md, en_ac, pc_sel, ma_sel, md_sel, ac_sel, alu_sub, rd, wr;
  } ctl_t;

  int         mpos  = 0;
  logic       mhalt = 1'b0;
  logic [3:0] mir   = 4'h0;

  function automatic ctl_t rules(input int pos, input logic [3:0] op, input logic n, input logic z);
    ctl_t c;
    int   step;
    c = '0;
    step = pos - 4;
    if (pos == 0) c.en_ma = 1'b1;
    else if (pos == 1) begin c.rd = 1'b1; c.en_md = 1'b1; c.en_pc = 1'b1; end
    else if (pos == 2) begin c.en_ma = 1'b1; c.ma_sel = 1'b1; end
    else if (pos >= 4) begin
      if (op == 4'h0 || op == 4'h2 || op == 4'h3) begin
        if (step == 1) begin c.rd = 1'b1; c.en_md = 1'b1; end
        if (step == 2) begin c.en_ac = 1'b1; c.ac_sel = (op != 4'h0); c.alu_sub = (op == 4'h3); end
      end
      if (op == 4'h1) begin
        if (step == 0) begin c.en_md = 1'b1; c.md_sel = 1'b1; end
        if (step == 1) c.wr = 1'b1;
      end
      if (step == 0 && (op == 4'h4 || (op == 4'h5 && n) || (op == 4'h6 && z))) begin
        c.en_pc = 1'b1; c.pc_sel = 1'b1;
      end
    end
    return c;
  endfunction

  always @(posedge CLK or negedge RESET) begin
    ctl_t c;
    if (!RESET) begin
      mpos <= 0; mhalt <= 1'b0; mir <= 4'h0;
    end else if (!mhalt) begin
      c = rules(mpos, mir, ac[15], ac == 16'd0);
      if (!((c.rd || c.wr) && !ready)) begin
        if (mpos == 2) mir <= md[15:12];
        if (mpos == 7) begin
          mpos <= 0;
          if (mir == 4'hF) mhalt <= 1'b1;
        end else mpos <= mpos + 1;
      end
    end
  end

  function automatic logic [29:0] exp_vec();
    ctl_t c;
    logic [3:0] ph;
    logic f, e, ft1;
    c = '0; ph = '0; f = 1'b0; e = 1'b0; ft1 = 1'b0;
    if (!mhalt) begin
      ph  = 4'b1000 >> (mpos % 4);
      f   = (mpos < 4);
      e   = !f;
      ft1 = (mpos == 1);
      c   = rules(mpos, mir, ac[15], ac == 16'd0);
      if (!RESET) c = '0;
      else if ((c.rd || c.wr) && !ready) begin
        c.en_pc = 1'b0; c.en_ma = 1'b0; c.en_md = 1'b0; c.en_ac = 1'b0;
      end
    end
    return {ph, f, e, ft1, mir, mir == 4'h0, mir == 4'h1, mir == 4'h2, mir == 4'h3,
            mir == 4'h4, mir == 4'h5, mir == 4'h6, c, mhalt};
  endfunction

  function automatic logic [29:0] act_vec();
    return {T0, T1, T2, T3, FETCH, EXECUTE, FETCH_T1, IR_OUT,
            I_LDA, I_STA, I_ADD, I_SUB, I_JMP, I_BAN, I_BAZ,
            EN_PC, EN_MA, EN_MD, EN_AC, PC_SEL, MA_SEL, MD_SEL, AC_SEL, ALU_SUB,
            MEM_RD, MEM_WR, HALTED};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %h, want %h", name, got, want);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic run_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!HALTED && n < budget) begin
      @(posedge CLK); #1; n++;
    end
    chk({name, "_halt_reached"}, {31'd0, HALTED}, 32'd1);
  endtask

  task automatic wait_model(input string name, input int pos, input logic [3:0] op, input int budget);
    int  n;
    logic found;
    n = 0; found = 1'b0;
    while (!found && n < budget) begin
      @(negedge CLK); n++;
      if (mpos == pos && mir == op && !mhalt) found = 1'b1;
    end
    chk({name, "_reached"}, {31'd0, found}, 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) init_mem[i] = 16'h9000;
  endtask

  initial begin
    int n, rd_cnt, pc_cnt, ex_cnt;
    logic done;

    fork
      forever begin
        @(negedge CLK);
        chk("cycle_compare", {2'b00, act_vec()}, {2'b00, exp_vec()});
      end
    join_none

    // Program 1: LDA A, ADD B, STA C, HALT
    clear_mem();
    init_mem[0] = 16'h000A; init_mem[1] = 16'h200B; init_mem[2] = 16'h100C;
    init_mem[3] = 16'hF000; init_mem[10] = 16'h0005; init_mem[11] = 16'h0003;
    init_mem[12] = 16'h0000;
    @(negedge CLK);
    chk("reset_quiet", {19'd0, EN_PC, EN_MA, EN_MD, EN_AC, MEM_RD, MEM_WR, T0, FETCH, IR_OUT, HALTED},
        {19'd0, 6'b000000, 2'b11, 4'h0, 1'b0});
    do_reset();
    @(negedge CLK);
    chk("first_fetch_t0", {28'd0, EN_MA, MA_SEL, T0, FETCH}, {28'd0, 4'b1011});
    n = 1;
    while (!HALTED && n < 100) begin @(posedge CLK); #1; n++; end
    chk("prog1_cycles", n, 32'd33);
    chk("prog1_mem_c", {16'd0, mem[12]}, 32'h0008);
    chk("prog1_pc", {20'd0, pc}, 32'h004);
    chk("prog1_ac", {16'd0, ac}, 32'h0008);

    // Program 2: LDA 0x10, SUB 0x11, BAN 0x20 with branch taken then not taken
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      init_mem[0] = 16'h0010; init_mem[1] = 16'h3011; init_mem[2] = 16'h5020;
      init_mem[3] = 16'hF000; init_mem[32] = 16'hF000;
      init_mem[16] = (pass == 0) ? 16'h0001 : 16'h0004; init_mem[17] = 16'h0003;
      do_reset();
      wait_model("ban_t0", 4, 4'h5, 100);
      if (pass == 0) begin
        chk("ban_taken_ac", {16'd0, ac}, 32'hFFFE);
        chk("ban_taken_ctl", {30'd0, EN_PC, PC_SEL}, 32'd3);
      end else begin
        chk("ban_not_taken_ac", {16'd0, ac}, 32'h0001);
        chk("ban_not_taken_ctl", {30'd0, EN_PC, PC_SEL}, 32'd0);
      end
      run_halt("prog2", 100);
      chk("prog2_pc", {20'd0, pc}, (pass == 0) ? 32'h021 : 32'h004);
    end

    // Program 3: undefined opcode 0x9 with a 3-cycle fetch stall, then HALT
    clear_mem();
    init_mem[0] = 16'h9000; init_mem[1] = 16'hF000;
    do_reset();
    n = 0; rd_cnt = 0; pc_cnt = 0; ex_cnt = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(posedge CLK); #1; n++;
      if (n == 1) ready = 1'b0;
      if (n == 4) ready = 1'b1;
      @(negedge CLK);
      if (MEM_RD) rd_cnt++;
      if (EN_PC) pc_cnt++;
      if (EXECUTE && (EN_PC || EN_MA || EN_MD || EN_AC || MEM_RD || MEM_WR)) ex_cnt++;
      if (FETCH && T0) done = 1'b1;
    end
    ready = 1'b1;
    chk("stall_instr_cycles", n, 32'd11);
    chk("stall_rd_cycles", rd_cnt, 32'd4);
    chk("stall_pc_pulses", pc_cnt, 32'd1);
    chk("nop_exec_quiet", ex_cnt, 32'd0);
    run_halt("prog3", 40);
    chk("prog3_pc", {20'd0, pc}, 32'h002);

    // Reset during STA execute T1 while MEM_WR is high
    clear_mem();
    init_mem[0] = 16'h000A; init_mem[1] = 16'h200B; init_mem[2] = 16'h100C;
    init_mem[3] = 16'hF000; init_mem[10] = 16'h0005; init_mem[11] = 16'h0003;
    do_reset();
    wait_model("sta_t1", 5, 4'h1, 100);
    #1;
    chk("sta_wr_high", {31'd0, MEM_WR}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("async_reset_drop", {25'd0, MEM_WR, T0, FETCH, IR_OUT}, {25'd0, 3'b011, 4'h0});
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("post_reset_fetch", {24'd0, EN_MA, MA_SEL, T0, FETCH, IR_OUT}, {24'd0, 4'b1011, 4'h0});
    run_halt("prog4", 100);
    chk("prog4_mem_c", {16'd0, mem[12]}, 32'h0008);

    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
